// File: rtl/pipe_pkg.sv
// Shared widths, ctrl-field bit positions and the side-effect mask for the ID/EX stage.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_PC_W     = 7;
  localparam int unsigned DEF_RA_W     = 5;
  localparam int unsigned DEF_ALU_OP_W = 6;
  localparam int unsigned DEF_CNT_W    = 16;

  // Single-bit ctrl fields occupy the low bits; alu_op sits above them.
  localparam int unsigned CTRL_LO_W       = 7;
  localparam int unsigned CTRL_W          = DEF_ALU_OP_W + CTRL_LO_W;
  localparam int unsigned CTRL_MEM_TO_REG = 0;
  localparam int unsigned CTRL_REG_WRITE  = 1;
  localparam int unsigned CTRL_MEM_READ   = 2;
  localparam int unsigned CTRL_MEM_WRITE  = 3;
  localparam int unsigned CTRL_BRANCH     = 4;
  localparam int unsigned CTRL_ALU_SRC    = 5;
  localparam int unsigned CTRL_REG_DST    = 6;
  localparam int unsigned CTRL_ALU_OP_LSB = 7;

  // Controls that must never reach EX from a bubble.
  localparam logic [CTRL_LO_W-1:0] SIDE_FX_MASK = (7'(1) << CTRL_BRANCH)
                                                | (7'(1) << CTRL_MEM_WRITE)
                                                | (7'(1) << CTRL_MEM_READ)
                                                | (7'(1) << CTRL_REG_WRITE);

endpackage

// File: rtl/skid_reg2.sv
// Generic two-entry skid buffer: main entry drives the output, skid entry absorbs one beat
// of backpressure. in_ready comes straight from a flop, so out_ready never reaches it.
module skid_reg2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   occupancy_o
);

  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic         accept, deliver;

  assign accept  = in_valid_i & ~skid_v_q;
  assign deliver = main_v_q & out_ready_i;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (!main_v_q) begin
      if (accept) begin
        main_d   = in_data_i;
        main_v_d = 1'b1;
      end
    end else if (!skid_v_q) begin
      if (accept && deliver) begin
        main_d = in_data_i;
      end else if (accept) begin
        skid_d   = in_data_i;
        skid_v_d = 1'b1;
      end else if (deliver) begin
        main_v_d = 1'b0;
      end
    end else if (deliver) begin
      main_d   = skid_q;
      skid_v_d = 1'b0;
    end
    // Payload may keep stale contents; only the valid bits are squashed.
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign in_ready_o  = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_q;
  assign occupancy_o = 2'(main_v_q) + 2'(skid_v_q);

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register: packs the decoded instruction into a skid buffer, masks
// side-effect controls on bubbles and counts EX backpressure cycles.
module id_ex_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned PC_W     = DEF_PC_W,
  parameter int unsigned RA_W     = DEF_RA_W,
  parameter int unsigned ALU_OP_W = DEF_ALU_OP_W,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [ALU_OP_W+CTRL_LO_W-1:0] in_ctrl_i,
  input  logic [PC_W-1:0]               in_pc_i,
  input  logic [DATA_W-1:0]             in_data1_i,
  input  logic [DATA_W-1:0]             in_data2_i,
  input  logic [DATA_W-1:0]             in_imm_i,
  input  logic [RA_W-1:0]               in_reg1_i,
  input  logic [RA_W-1:0]               in_reg2_i,
  input  logic [RA_W-1:0]               in_rs_i,
  input  logic [RA_W-1:0]               in_rt_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [ALU_OP_W+CTRL_LO_W-1:0] out_ctrl_o,
  output logic [PC_W-1:0]               out_pc_o,
  output logic [DATA_W-1:0]             out_data1_o,
  output logic [DATA_W-1:0]             out_data2_o,
  output logic [DATA_W-1:0]             out_imm_o,
  output logic [RA_W-1:0]               out_reg1_o,
  output logic [RA_W-1:0]               out_reg2_o,
  output logic [RA_W-1:0]               out_rs_o,
  output logic [RA_W-1:0]               out_rt_o,
  output logic [1:0]                    occupancy_o,
  output logic [CNT_W-1:0]              stall_cnt_o
);

  localparam int unsigned CtrlW    = ALU_OP_W + CTRL_LO_W;
  localparam int unsigned PayloadW = CtrlW + PC_W + 3 * DATA_W + 4 * RA_W;
  localparam logic [CtrlW-1:0] CtrlMask = {{ALU_OP_W{1'b0}}, SIDE_FX_MASK};

  logic [PayloadW-1:0] in_payload, out_payload;
  logic [CtrlW-1:0]    main_ctrl;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  assign in_payload = {in_ctrl_i, in_pc_i, in_data1_i, in_data2_i, in_imm_i,
                       in_reg1_i, in_reg2_i, in_rs_i, in_rt_i};

  skid_reg2 #(
    .W(PayloadW)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_payload),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_payload),
    .occupancy_o (occupancy_o)
  );

  assign {main_ctrl, out_pc_o, out_data1_o, out_data2_o, out_imm_o,
          out_reg1_o, out_reg2_o, out_rs_o, out_rt_o} = out_payload;

  assign out_ctrl_o = out_valid_o ? main_ctrl : (main_ctrl & ~CtrlMask);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Parametrised ID/EX pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Accepts one decoded instruction per cycle from ID and presents it to EX one cycle later.
- Supports backpressure from EX, flush (branch or exception squash) and bubble masking of side-effect controls.
- Replaces the fixed-width, always-enabled ID/EX latch.

Parameters:
- DATA_W, 32, width of data1/data2/immediate
- PC_W, 7, width of the next-PC field
- RA_W, 5, register-address width
- ALU_OP_W, 6, ALU opcode width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  squash all held entries
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  ALU_OP_W+7  {alu_op, reg_dst, alu_src, branch, mem_write, mem_read, reg_write, mem_to_reg}, MSB first
- in_pc  in  PC_W  next PC
- in_data1, in_data2  in  DATA_W  register-file read data
- in_imm  in  DATA_W  sign-extended immediate
- in_reg1, in_reg2, in_rs, in_rt  in  RA_W  register addresses
- out_valid  out  1  EX-side entry valid
- out_ready  in  1  EX consumes this cycle
- out_ctrl, out_pc, out_data1, out_data2, out_imm, out_reg1, out_reg2, out_rs, out_rt  out  same widths as inputs
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with a valid bit (main_v, skid_v); occupancy = main_v + skid_v.
- in_ready = !skid_v, driven from a register. There is no combinational path from out_ready to in_ready.
- Handshake terms: accept = in_valid & in_ready; deliver = main_v & out_ready; out_valid = main_v.
- Latency is 1 cycle (accepted at edge N, visible after edge N); sustained throughput is 1 per cycle when out_ready=1.
- occ0: accept -> main loads, occ1.
- occ1:
  - accept & deliver -> main loads new entry, stays occ1.
  - accept & !deliver -> skid loads, occ2.
  - !accept & deliver -> occ0.
  - otherwise hold.
- occ2 (in_ready=0): deliver -> main <= skid, skid_v <= 0, occ1; otherwise hold everything.
- Order preserved: skid is never bypassed by a newer entry.
- flush: next state main_v = skid_v = 0. An accept in the same cycle is discarded. Payload registers may retain stale data. in_ready is 1 the cycle after a flush.
- flush & deliver in the same cycle: the delivered entry counts as consumed by EX. EX must ignore it via its own flush.
- rst has priority over flush. It clears main_v, skid_v and every payload register to 0; all outputs read 0, including stall_cnt and occupancy.
- Bubble masking: when out_valid=0, the out_ctrl bits branch, mem_write, mem_read and reg_write are forced to 0 combinationally. Other outputs show main-register contents.
- stall_cnt increments when out_valid & !out_ready and saturates at all-ones. Only rst clears it; flush does not.
- Data is held stable while out_valid & !out_ready (no change until delivered or flushed).

Decomposition:
- Shared package pipe_pkg holds:
  - width constants (DATA_W, PC_W, RA_W, ALU_OP_W defaults);
  - CTRL_W = ALU_OP_W+7;
  - bit-index constants for each ctrl field;
  - the side-effect mask constant (branch | mem_write | mem_read | reg_write).
- Payload is concatenated into one PAYLOAD_W vector.
- One sub-module, skid_reg2 (generic 2-entry skid buffer on a W-wide vector with flush), holds all state. The top level packs and unpacks fields, applies the mask and runs stall_cnt.

Test Plan:
- rst held 2 cycles, then released -> out_valid=0, in_ready=1, occupancy=0, all outputs 0, stall_cnt=0.
- Streaming with out_ready=1, 5 entries in_data1=1..5 on consecutive cycles -> out_data1=1..5 on consecutive cycles, each 1 cycle after acceptance; occupancy stays 1.
- Backpressure:
  - Send A=0x11, B=0x22 with out_ready=0 -> occupancy=2, in_ready=0, out_data1 stays 0x11.
  - Third input C is held off.
  - Then out_ready=1 -> A, B, C delivered in order.
  - stall_cnt equals the number of stalled cycles.
- Flush at occ2, in_valid=1 with data 0x33 the same cycle -> next cycle out_valid=0, occupancy=0, in_ready=1; 0x33 never appears. With in_ctrl=all ones, out_ctrl has branch/mem_write/mem_read/reg_write = 0.
- rst asserted with flush=1 at occ2 -> payload zeroed, occupancy=0. Force stall for 2^CNT_W+3 cycles (CNT_W=4 build) -> stall_cnt saturates at 15.
